// File: rtl/data_mem_mmio_if.sv
// Core data bus plus the transmit stream, bundled between the core side and the memory subsystem.
// Stream handshake: a word transfers on a rising edge where tx_valid && tx_ready; while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold.
interface data_mem_mmio_if;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic        data_wr;
    logic [31:0] data_in;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output data_addr, data_out, data_wr, tx_ready,
        input  data_in, tx_data, tx_valid
    );

    modport slave (
        input  data_addr, data_out, data_wr, tx_ready,
        output data_in, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data-side memory for a single-cycle core: word RAM, memory-mapped transmit FIFO and cycle counter.
// Loads are combinational; every state change happens on the rising clock edge.
module data_mem_mmio #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    data_mem_mmio_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [29:0] TX_WADDR     = 30'h3FFF_C000;
    localparam logic [29:0] STATUS_WADDR = 30'h3FFF_C001;
    localparam logic [29:0] CYCLE_WADDR  = 30'h3FFF_C002;

    localparam logic [PW-1:0] PTR_ONE   = 1;
    localparam logic [PW:0]   CNT_ONE   = 1;
    localparam logic [PW:0]   CNT_DEPTH = FIFO_DEPTH;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [31:0]   storage_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   cycle_q, cycle_d;

    logic [29:0]   waddr;
    logic [AW-1:0] word_idx;
    logic          is_ram, is_tx, is_status, is_cycle;
    logic          empty, full, pop, push_req, push_ok;
    logic [31:0]   rdata;

    // Only the word address matters; byte offset bits are dropped.
    assign waddr     = bus.data_addr[31:2];
    assign word_idx  = bus.data_addr[AW+1:2];
    assign is_ram    = (bus.data_addr[31:AW+2] == '0);
    assign is_tx     = (waddr == TX_WADDR);
    assign is_status = (waddr == STATUS_WADDR);
    assign is_cycle  = (waddr == CYCLE_WADDR);

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_DEPTH);
    assign pop      = !empty && bus.tx_ready;
    assign push_req = bus.data_wr && is_tx;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) count_d = count_q + CNT_ONE;
        else if (pop && !push_ok) count_d = count_q - CNT_ONE;
        overflow_d = overflow_q;
        if (push_req && full && !pop) overflow_d = 1'b1;
        else if (bus.data_wr && is_status && bus.data_out[2]) overflow_d = 1'b0;
        cycle_d    = (bus.data_wr && is_cycle) ? bus.data_out : cycle_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) storage_q[i] <= '0;
        end else begin
            if (push_ok) storage_q[wr_ptr_q] <= bus.data_out;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
        end
    end

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bus.data_wr && is_ram) ram_q[word_idx] <= bus.data_out;
    end

    always_comb begin
        rdata = '0;
        if (is_ram)         rdata = ram_q[word_idx];
        else if (is_status) rdata = {29'b0, overflow_q, full, empty};
        else if (is_cycle)  rdata = cycle_q;
    end

    assign bus.data_in  = rdata;
    assign bus.tx_data  = storage_q[rd_ptr_q];
    assign bus.tx_valid = !empty;
endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory subsystem directly downstream of the single-cycle MIPS core. It consumes the core's data_addr/data_out/data_wr and returns data_in. It contains a word-addressed data RAM, a memory-mapped transmit FIFO with a valid/ready output stream, and a memory-mapped 32-bit cycle counter. Reads are combinational so a load completes in the core's single cycle; all state updates occur on the rising clock edge.

## Interface
- RAM_WORDS, 256, data RAM depth in 32-bit words; power of two, at most 2^14.
- FIFO_DEPTH, 4, transmit FIFO entries; power of two, at least 2.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_addr  input  32  byte address from the core.
- data_out  input  32  store data from the core.
- data_wr  input  1  store enable from the core.
- data_in  output  32  load data to the core; combinational.
- tx_data  output  32  FIFO head word.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts the head word this cycle.

## Operation
- Address decode uses the full 32 bits. data_addr[1:0] are ignored everywhere, so every access is a word access.
- RAM region: addresses 0x0000_0000 to 4*RAM_WORDS-1. The word index is data_addr[log2(RAM_WORDS)+1:2].
  - Read returns the stored word.
  - When data_wr=1, the word is written at the clock edge.
- TX_DATA register, 0xFFFF_0000:
  - Write pushes data_out into the FIFO.
  - Read returns 0.
- STATUS register, 0xFFFF_0004:
  - Read returns {29'b0, overflow, full, empty}.
  - Write with data_out[2]=1 clears overflow. Other bits of the write are ignored.
- CYCLE register, 0xFFFF_0008:
  - Read returns the counter value.
  - Write loads data_out into the counter.
- Any other address: read returns 0; write has no effect.
- FIFO:
  - Circular buffer with read pointer, write pointer and occupancy count (0..FIFO_DEPTH).
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - tx_valid = !empty; tx_data = storage[rd_ptr].
- Pop: occurs when tx_valid && tx_ready. rd_ptr advances and wraps modulo FIFO_DEPTH.
- Push when not full: the word is stored at wr_ptr. wr_ptr advances and wraps modulo FIFO_DEPTH.
- Push while full with no pop in the same cycle: the word is dropped and overflow is set (sticky). Count and pointers are unchanged.
- Push while full with a pop in the same cycle: the push is accepted, count stays FIFO_DEPTH, overflow is not set.
- Push and pop in the same cycle with 0 < count < FIFO_DEPTH: both occur and count is unchanged.
- Push when empty with tx_ready=1: the word is not bypassed. It appears on tx_data in the next cycle.
- Overflow set and clear in the same cycle: set wins.
- Cycle counter:
  - Free-running +1 per clock; wraps from 0xFFFF_FFFF to 0.
  - A CYCLE write loads data_out at that edge instead of incrementing; counting resumes from the loaded value on the next edge.
- RAM contents are not reset; they are undefined until written.

## Timing
- Reset, asynchronous on rst=1:
  - FIFO pointers, count, all FIFO storage, overflow and counter are cleared to 0.
  - Resulting outputs: tx_valid=0, tx_data=0.
  - data_in follows decode, e.g. STATUS reads 0x1.
- Reset asserted mid-operation discards all FIFO contents immediately, without waiting for a clock edge.
- Load latency: 0 cycles. data_in is valid in the same cycle that data_addr is presented.
- Store latency: data is written at edge N and readable from cycle N+1.
- TX push at edge N: tx_valid=1 and the word is on tx_data from cycle N+1.
- Pop handshake:
  - The consumer samples tx_data at the edge where tx_valid && tx_ready.
  - tx_data and tx_valid are held stable while tx_valid=1 and tx_ready=0.
- STATUS and CYCLE reads reflect the registered state before the current edge.

## Test plan
- Reset release, then read STATUS -> data_in=0x0000_0001; tx_valid=0; CYCLE reads 0 in the first cycle, then 1, 2, ...
- Store 0xDEADBEEF to 0x0000_0010, then load from 0x0000_0013 -> data_in=0xDEADBEEF. Load from 0x0000_0400 (with RAM_WORDS=256) -> data_in=0.
- tx_ready=0; write TX_DATA 1..5 -> after the 4th write STATUS=0x2; after the 5th write STATUS=0x6. Raise tx_ready -> tx_data sequence 1,2,3,4, then tx_valid=0 and STATUS=0x5.
- FIFO full with tx_ready=1, write TX_DATA 9 in the same cycle as a pop -> overflow stays 0 and word 9 appears after the existing entries. Write 0x4 to STATUS -> STATUS=0x1 once the FIFO has drained.
- Write 0xFFFF_FFFE to CYCLE -> subsequent reads give 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Push 3 words, then assert rst between clock edges -> tx_valid drops immediately. After release STATUS=0x1 and CYCLE restarts from 0.
